// File: rtl/elastic_delay_pkg.sv
// Shared definitions for the elastic delay line: default data width and the
// occupancy counter width helper.
package elastic_delay_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Width needed to count 0..cycles valid stages; never narrower than 1 bit.
    function automatic int occ_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/elastic_delay_stage.sv
// One valid+data register pair of the elastic delay line. Data is reset to
// INIT_VAL only when ELASTIC_DELAY_DATA_RST_EN is defined.
module elastic_delay_stage
    import elastic_delay_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             ready_in,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst)
            valid <= 1'b0;
        else if (ready_in)
            valid <= up_valid;
    end

`ifdef ELASTIC_DELAY_DATA_RST_EN
    always_ff @(posedge clk) begin
        if (rst)
            data <= INIT_VAL;
        else if (ready_in && up_valid)
            data <= up_data;
    end
`else
    // Data registers carry no reset; the stage is only meaningful while valid.
    always_ff @(posedge clk) begin
        if (ready_in && up_valid)
            data <= up_data;
    end

    logic unused_init;
    assign unused_init = ^INIT_VAL;
`endif

endmodule

// File: rtl/elastic_delay.sv
// Elastic delay line: CYCLES valid/ready register stages with bubble collapse.
// Optional data reset to INIT_VAL under ELASTIC_DELAY_DATA_RST_EN.
module elastic_delay
    import elastic_delay_pkg::*;
#(
    parameter int               CYCLES   = 4,
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [occ_width(CYCLES)-1:0]   occupancy
);

    localparam int OW = occ_width(CYCLES);

    generate
        if (CYCLES < 0) begin : g_bad
            $error("elastic_delay: CYCLES must be >= 0 (got %0d)", CYCLES);
        end else if (CYCLES == 0) begin : g_pass
            assign out_valid = in_valid;
            assign in_ready  = out_ready;
            assign out_data  = in_data;
            assign occupancy = '0;

            logic unused_pt;
            assign unused_pt = ^{clk, rst, INIT_VAL};
        end else begin : g_pipe
            // Entry 0 is the upstream port; entry i+1 is the output of stage i.
            logic [CYCLES:0]            chain_valid;
            logic [CYCLES:0][WIDTH-1:0] chain_data;
            logic [CYCLES:0]            ready;
            logic [OW-1:0]              cnt;

            assign chain_valid[0] = in_valid;
            assign chain_data[0]  = in_data;
            assign ready[CYCLES]  = out_ready;

            for (genvar i = 0; i < CYCLES; i++) begin : g_stage
                // A stage accepts when empty or when its occupant moves on.
                assign ready[i] = !chain_valid[i+1] || ready[i+1];

                elastic_delay_stage #(
                    .WIDTH    (WIDTH),
                    .INIT_VAL (INIT_VAL)
                ) u_stage (
                    .clk      (clk),
                    .rst      (rst),
                    .up_valid (chain_valid[i]),
                    .up_data  (chain_data[i]),
                    .ready_in (ready[i]),
                    .valid    (chain_valid[i+1]),
                    .data     (chain_data[i+1])
                );
            end

            always_comb begin
                cnt = '0;
                for (int i = 1; i <= CYCLES; i++)
                    cnt = cnt + OW'(chain_valid[i]);
            end

            // Status outputs are forced idle for the whole reset cycle, not
            // just after the reset edge.
            assign in_ready  = ready[0] && !rst;
            assign out_valid = chain_valid[CYCLES] && !rst;
            assign out_data  = chain_data[CYCLES];
            assign occupancy = rst ? '0 : cnt;
        end
    endgenerate

endmodule

// File: tb/tb_elastic_delay.sv
// Bench for elastic_delay: CYCLES=4 pipe against a word-position model and
// scoreboard, plus a CYCLES=0 pass-through instance.
module tb_elastic_delay;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [2:0] occupancy;

    logic       p_in_valid, p_in_ready, p_out_valid, p_out_ready;
    logic [7:0] p_in_data, p_out_data;
    logic [0:0] p_occupancy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    elastic_delay #(.CYCLES(C), .WIDTH(8), .INIT_VAL(8'h5A)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    elastic_delay #(.CYCLES(0), .WIDTH(8)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
        .occupancy(p_occupancy)
    );

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: ordered list of word positions (front = oldest). A word is stuck
    // only if it belongs to the unbroken run of words ending at a stalled output.
    int         pos_q[$];
    logic [7:0] sb[$];

    always @(negedge clk) begin
        if (!rst && in_valid && in_ready)
            sb.push_back(in_data);
    end

    always @(negedge clk) begin
        int   k, stuck;
        bit   exp_ov, exp_ir;
        int   nq[$];
        if (rst) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_occupancy", occupancy, 0);
            check("rst_in_ready", in_ready, 0);
            pos_q.delete();
            sb.delete();
        end else begin
            k = 0;
            while (k < pos_q.size() && pos_q[k] == C - 1 - k) k++;
            exp_ov = (pos_q.size() > 0) && (pos_q[0] == C - 1);
            exp_ir = !(k == C && !out_ready);
            check("out_valid", out_valid, exp_ov);
            check("in_ready", in_ready, exp_ir);
            check("occupancy", occupancy, pos_q.size());
            if (exp_ov && sb.size() > 0)
                check("out_data", out_data, sb[0]);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", out_data, $time);
                end else begin
                    void'(sb.pop_front());
                end
            end
            stuck = out_ready ? 0 : k;
            nq = {};
            for (int j = 0; j < pos_q.size(); j++) begin
                if (j < stuck)
                    nq.push_back(pos_q[j]);
                else if (!(j == 0 && exp_ov && out_ready))
                    nq.push_back(pos_q[j] + 1);
            end
            if (in_valid && exp_ir)
                nq.push_back(0);
            pos_q = nq;
        end
    end

    always @(negedge clk) begin
        check("pt_out_valid", p_out_valid, p_in_valid);
        check("pt_in_ready", p_in_ready, p_out_ready);
        check("pt_out_data", p_out_data, p_in_data);
        check("pt_occupancy", p_occupancy, 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
        p_in_valid  = 1'($urandom_range(0, 1));
        p_out_ready = 1'($urandom_range(0, 1));
        p_in_data   = 8'($urandom);
    endtask

    task automatic drain(int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        p_in_valid = 1'b0; p_out_ready = 1'b0; p_in_data = '0;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Back-to-back stream with no backpressure.
        out_ready = 1'b1;
        for (int v = 1; v <= 16; v++) begin
            in_valid = 1'b1; in_data = 8'(v);
            step();
        end
        drain(6);

        // Fill with output stalled, hold 10 cycles, then drain.
        out_ready = 1'b0;
        for (int v = 0; v < 4; v++) begin
            in_valid = 1'b1; in_data = 8'hA0 + 8'(v);
            step();
        end
        in_data = 8'hEE;
        @(negedge clk);
        check("full_occupancy", occupancy, 4);
        check("full_in_ready", in_ready, 0);
        repeat (10) begin
            step();
            check("stall_out_data", out_data, 8'hA0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(6);

        // Bubble collapse behind a stalled output.
        in_valid = 1'b1; in_data = 8'h11; step();
        in_valid = 1'b0; step(); step();
        in_valid = 1'b1; in_data = 8'h22; step();
        in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        @(negedge clk);
        check("bubble_occupancy", occupancy, 2);
        check("bubble_in_ready", in_ready, 1);
        step();
        @(negedge clk);
        check("bubble_hold_occ", occupancy, 2);
        drain(6);

        // Full pipe with simultaneous push and pop.
        out_ready = 1'b0;
        for (int v = 0; v < 4; v++) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            step();
        end
        for (int n = 0; n < 20; n++) begin
            in_valid = 1'b1; out_ready = 1'b1; in_data = 8'($urandom);
            @(negedge clk);
            check("pushpop_occupancy", occupancy, 4);
            step();
        end
        drain(6);

        // Reset with three words in flight.
        out_ready = 1'b0;
        for (int v = 0; v < 3; v++) begin
            in_valid = 1'b1; in_data = 8'hC0 + 8'(v);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("prerst_occupancy", occupancy, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("postrst_out_valid", out_valid, 0);
        check("postrst_occupancy", occupancy, 0);
`ifdef ELASTIC_DELAY_DATA_RST_EN
        check("postrst_out_data", out_data, 8'h5A);
`endif
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            in_valid = 1'b1; in_data = 8'h30 + 8'(v);
            step();
        end
        drain(6);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            step();
        end
        drain(8);
        check("end_scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
